wrr_datapath: RTL and testbench
===============================

Name: wrr_datapath

Overview:
Weighted round-robin datapath that sits directly downstream of the arbiter controller. It consumes the controller's ld_request, ld_grant, ld_weight and ld_count strobes, and it returns grant[7:0] and the count-done flag contrl1 that close the controller loop. The block holds the request register, the rotating priority pointer, the one-hot grant register, the weight lookup and the grant-duration down-counter.

Parameters:
N, 8, number of requesters; width of req_in and grant.
WW, 4, weight width per requester.
IW, 3, pointer/index width, equal to clog2(N).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_in  input  N  raw request vector; bit i is requester i.
weights_in  input  N*WW  packed weights; requester i occupies [i*WW +: WW].
ld_request  input  1  capture req_in into req_r.
ld_grant  input  1  evaluate round-robin arbitration and load grant.
ld_weight  input  1  load the weight of the granted requester into the counter.
ld_count  input  1  decrement enable for the grant-duration counter.
grant  output  N  registered one-hot grant, or all zeros.
contrl1  output  1  registered count-done pulse.

Behaviour:
- Reset, synchronous, highest priority over every strobe:
  - req_r=0, grant=0, ptr=0, count_r=0, contrl1=0.
  - Reset asserted mid-count abandons the grant; no contrl1 pulse is produced.
- Request register:
  - ld_request=1 -> req_r<=req_in on the next edge.
  - Arbitration in the same cycle uses the old req_r (one-cycle latency).
- Arbitration on ld_grant=1:
  - Winner = first set bit of req_r scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (circular).
  - Winner found: grant<=one-hot(winner) and ptr<=(winner+1) mod N. The wrap from N-1 gives ptr=0.
  - req_r=0: grant<=0 and ptr unchanged.
  - ld_grant=0: grant and ptr hold. The grant stays stable for the whole counting phase.
- Weight and counter, priority ld_weight > ld_count:
  - ld_weight=1 and grant!=0: count_r<=W_eff, the weight slice of the granted index.
    - A weight of 0 is treated as 1 (minimum one-cycle tenure).
    - The slice is selected from the grant value registered before this edge.
  - ld_weight=1 and grant==0: ignored; count_r holds.
  - ld_count=1 and ld_weight=1 in the same cycle: the load wins and no decrement occurs. The controller issues both strobes together.
  - ld_count=1, ld_weight=0 and count_r!=0: count_r<=count_r-1.
  - ld_count=1 and count_r==0: hold at 0; no underflow, no pulse.
  - count_r is WW bits wide and its arithmetic never wraps.
- Done pulse:
  - contrl1<=1 on exactly the edge where count_r goes 1->0. It is cleared on the following edge.
  - It is asserted for one cycle, after W_eff decrementing ld_count cycles following the load.
- Simultaneous ld_grant and ld_weight: the weight uses the pre-edge grant, and the new grant registers at the same time.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package wrr_pkg holds:
  - Constants: N, WW, IW.
  - Types: idx_t [IW-1:0], weight_t [WW-1:0], req_vec_t [N-1:0].
  - Helper function onehot_to_idx.
- Sub-module rr_priority_picker: purely combinational.
  - Inputs: req_r and ptr.
  - Outputs: one-hot winner, winner index, valid flag.
  - Implementation: rotate right by ptr, fixed-priority encode, rotate back.
- The registers and counter stay in wrr_datapath.

Test Plan:
- Reset: hold reset 2 cycles with all ld_* toggling -> grant=0, contrl1=0, ptr=0, count_r=0 on every cycle.
- Rotation with wrap: req_in=8'b0000_0101, pulse ld_request, then ld_grant three times.
  - Grants: 0x01 (ptr=1), 0x04 (ptr=3), 0x01 (ptr=1).
  - A further req_in=8'b1000_0000 case: grant=0x80, ptr=0.
- Weighted tenure: weight[2]=3 and grant=0x04; pulse ld_weight with ld_count, then hold ld_count.
  - contrl1 is high exactly one cycle, after the 3rd decrementing cycle; count_r=0 afterwards; holding ld_count yields no further pulses.
- Zero-weight and empty cases:
  - weight[0]=0 -> one decrementing ld_count gives contrl1 after 1 cycle.
  - req_r=0 with ld_grant -> grant=0, ptr unchanged, and a later ld_weight leaves count_r unchanged.
- Reset mid-count: weight=15, assert reset after 5 decrements -> count_r=0, grant=0, and contrl1 never pulses.
- Closed loop with the controller: req_in=0xFF, all weights=2.
  - Grants cycle 0x01, 0x02, ..., 0x80, 0x01.
  - Each grant is held for exactly 2 counting cycles, with one contrl1 per grant.

Source files
------------

// File: rtl/wrr_pkg.sv
// Shared sizing, types and helpers for the weighted round-robin datapath.
package wrr_pkg;

  localparam int N  = 8;
  localparam int WW = 4;
  localparam int IW = 3;

  typedef logic [IW-1:0] idx_t;
  typedef logic [WW-1:0] weight_t;
  typedef logic [N-1:0]  req_vec_t;

  // Encodes a one-hot vector; an all-zero input returns index 0.
  function automatic idx_t onehot_to_idx(input req_vec_t oh);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational circular priority picker.
// It rotates the request vector so that ptr is at bit 0, takes the lowest set bit, and rotates back.
module rr_priority_picker
  import wrr_pkg::*;
(
  input  req_vec_t req,
  input  idx_t     ptr,
  output req_vec_t winner_oh,
  output idx_t     winner_idx,
  output logic     valid
);

  logic [2*N-1:0] dbl_fwd;
  logic [2*N-1:0] dbl_back;
  req_vec_t       rot;
  req_vec_t       first;
  idx_t           pos;

  always_comb begin
    dbl_fwd = {req, req} >> ptr;
    rot     = dbl_fwd[N-1:0];
    first   = rot & (~rot + req_vec_t'(1));

    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = idx_t'(i);
    end

    dbl_back   = {first, first} << ptr;
    winner_oh  = dbl_back[2*N-1:N];
    // N is a power of two, so index arithmetic wraps modulo N for free.
    winner_idx = pos + ptr;
    valid      = |req;
  end

endmodule

// File: rtl/wrr_datapath.sv
// Weighted round-robin datapath: request register, rotating pointer, one-hot grant,
// and a grant-duration down-counter with a done pulse (contrl1) returned to the controller.
module wrr_datapath
  import wrr_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_in,
  input  logic [N*WW-1:0] weights_in,
  input  logic            ld_request,
  input  logic            ld_grant,
  input  logic            ld_weight,
  input  logic            ld_count,
  output logic [N-1:0]    grant,
  output logic            contrl1
);

  req_vec_t req_r;
  idx_t     ptr;
  weight_t  count_r;

  req_vec_t pick_oh;
  idx_t     pick_idx;
  logic     pick_valid;

  idx_t     grant_idx;
  weight_t  w_sel;
  weight_t  w_eff;
  logic     do_load;
  logic     do_dec;

  rr_priority_picker u_picker (
    .req        (req_r),
    .ptr        (ptr),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // Weight is looked up from the grant held before the edge, so a simultaneous
  // ld_grant does not affect the value that is loaded.
  always_comb begin
    grant_idx = onehot_to_idx(grant);
    w_sel     = weights_in[grant_idx*WW +: WW];
    w_eff     = (w_sel == '0) ? weight_t'(1) : w_sel;
    do_load   = ld_weight && (grant != '0);
    do_dec    = ld_count && !ld_weight && (count_r != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_r   <= '0;
      ptr     <= '0;
      grant   <= '0;
      count_r <= '0;
      contrl1 <= 1'b0;
    end else begin
      if (ld_request) req_r <= req_in;

      if (ld_grant) begin
        if (pick_valid) begin
          grant <= pick_oh;
          ptr   <= pick_idx + idx_t'(1);
        end else begin
          grant <= '0;
        end
      end

      contrl1 <= 1'b0;
      if (do_load) begin
        count_r <= w_eff;
      end else if (do_dec) begin
        count_r <= count_r - weight_t'(1);
        if (count_r == weight_t'(1)) contrl1 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wrr_datapath.sv
// Directed self-checking bench for wrr_datapath: vector table plus hand-written
// sequences for reset mid-count and a closed controller loop.
module tb_wrr_datapath;

  logic        clk;
  logic        reset;
  logic [7:0]  req_in;
  logic [31:0] weights_in;
  logic        ld_request, ld_grant, ld_weight, ld_count;
  logic [7:0]  grant;
  logic        contrl1;

  int n_vec = 0;
  int n_err = 0;

  wrr_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .weights_in (weights_in),
    .ld_request (ld_request),
    .ld_grant   (ld_grant),
    .ld_weight  (ld_weight),
    .ld_count   (ld_count),
    .grant      (grant),
    .contrl1    (contrl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       lr, lg, lw, lc;
    logic [7:0] eg;
    logic       ec;
    logic [2:0] ep;
    logic [3:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] rq,
                       input logic lr, input logic lg, input logic lw, input logic lc);
    reset = r; req_in = rq;
    ld_request = lr; ld_grant = lg; ld_weight = lw; ld_count = lc;
  endtask

  int pulses;

  initial begin
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    // w7..w0 = 5,2,2,6,2,3,1,0
    weights_in = 32'h5226_2310;

    //                 rst  req    lr lg lw lc  grant  c  ptr cnt
    tbl.push_back('{1'b1, 8'hFF, 1'b1,1'b1,1'b1,1'b1, 8'h00,1'b0,3'd0,4'd0});
    tbl.push_back('{1'b1, 8'hFF, 1'b0,1'b0,1'b0,1'b0, 8'h00,1'b0,3'd0,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b1,1'b0,1'b0,1'b0, 8'h00,1'b0,3'd0,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b1,1'b0,1'b0, 8'h01,1'b0,3'd1,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b1,1'b0,1'b0, 8'h04,1'b0,3'd3,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b1,1'b0,1'b0, 8'h01,1'b0,3'd1,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b1,1'b0,1'b0, 8'h04,1'b0,3'd3,4'd0});
    // weighted tenure on requester 2 (weight 3)
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b1,1'b1, 8'h04,1'b0,3'd3,4'd3});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b0,1'b1, 8'h04,1'b0,3'd3,4'd2});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b0,1'b1, 8'h04,1'b0,3'd3,4'd1});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b0,1'b1, 8'h04,1'b1,3'd3,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b0,1'b1, 8'h04,1'b0,3'd3,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b0,1'b1, 8'h04,1'b0,3'd3,4'd0});
    // zero weight on requester 0 behaves as 1
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b1,1'b0,1'b0, 8'h01,1'b0,3'd1,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b1,1'b1, 8'h01,1'b0,3'd1,4'd1});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b0,1'b1, 8'h01,1'b1,3'd1,4'd0});
    tbl.push_back('{1'b0, 8'h05, 1'b0,1'b0,1'b0,1'b0, 8'h01,1'b0,3'd1,4'd0});
    // top requester: pointer wraps to 0
    tbl.push_back('{1'b0, 8'h80, 1'b1,1'b0,1'b0,1'b0, 8'h01,1'b0,3'd1,4'd0});
    tbl.push_back('{1'b0, 8'h80, 1'b0,1'b1,1'b0,1'b0, 8'h80,1'b0,3'd0,4'd0});
    // simultaneous ld_grant + ld_weight loads the old grant's weight (w7=5)
    tbl.push_back('{1'b0, 8'h02, 1'b1,1'b0,1'b0,1'b0, 8'h80,1'b0,3'd0,4'd0});
    tbl.push_back('{1'b0, 8'h02, 1'b0,1'b1,1'b1,1'b0, 8'h02,1'b0,3'd2,4'd5});
    // empty request: grant clears, ptr holds, ld_weight ignored
    tbl.push_back('{1'b0, 8'h00, 1'b1,1'b0,1'b0,1'b1, 8'h02,1'b0,3'd2,4'd4});
    tbl.push_back('{1'b0, 8'h00, 1'b0,1'b1,1'b0,1'b0, 8'h00,1'b0,3'd2,4'd4});
    tbl.push_back('{1'b0, 8'h00, 1'b0,1'b0,1'b1,1'b0, 8'h00,1'b0,3'd2,4'd4});
    // same-cycle ld_request + ld_grant arbitrates on the old (empty) req_r
    tbl.push_back('{1'b0, 8'h10, 1'b1,1'b1,1'b0,1'b0, 8'h00,1'b0,3'd2,4'd4});
    tbl.push_back('{1'b0, 8'h10, 1'b0,1'b1,1'b0,1'b0, 8'h10,1'b0,3'd5,4'd4});
    tbl.push_back('{1'b0, 8'h10, 1'b0,1'b0,1'b0,1'b1, 8'h10,1'b0,3'd5,4'd3});
    tbl.push_back('{1'b0, 8'h10, 1'b0,1'b0,1'b0,1'b1, 8'h10,1'b0,3'd5,4'd2});
    tbl.push_back('{1'b0, 8'h10, 1'b0,1'b0,1'b0,1'b1, 8'h10,1'b0,3'd5,4'd1});
    tbl.push_back('{1'b0, 8'h10, 1'b0,1'b0,1'b0,1'b1, 8'h10,1'b1,3'd5,4'd0});

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].lr, tbl[i].lg, tbl[i].lw, tbl[i].lc);
      tick();
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].eg));
      chk($sformatf("row%0d contrl1", i), 32'(contrl1), 32'(tbl[i].ec));
      chk($sformatf("row%0d ptr", i), 32'(dut.ptr), 32'(tbl[i].ep));
      chk($sformatf("row%0d count", i), 32'(dut.count_r), 32'(tbl[i].ecnt));
    end

    // Reset in the middle of a 15-cycle tenure.
    weights_in = 32'hFFFF_FFFF;
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("midrst grant", 32'(grant), 32'h01);
    drive(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    chk("midrst load", 32'(dut.count_r), 32'd15);
    drive(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    chk("midrst after5", 32'(dut.count_r), 32'd10);
    reset = 1'b1; tick();
    chk("midrst count", 32'(dut.count_r), 32'd0);
    chk("midrst grant0", 32'(grant), 32'h00);
    chk("midrst ptr", 32'(dut.ptr), 32'd0);
    chk("midrst contrl1", 32'(contrl1), 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (contrl1) pulses++;
    end
    chk("midrst no pulse", 32'(pulses), 32'd0);
    chk("midrst count hold", 32'(dut.count_r), 32'd0);

    // Closed loop: all requesting, all weights 2.
    weights_in = 32'h2222_2222;
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] eg;
      eg = 8'd1 << (k % 8);
      drive(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      chk($sformatf("loop%0d grant", k), 32'(grant), 32'(eg));
      chk($sformatf("loop%0d ptr", k), 32'(dut.ptr), 32'((k + 1) % 8));
      drive(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1); tick();
      chk($sformatf("loop%0d load", k), 32'(dut.count_r), 32'd2);
      if (contrl1) pulses++;
      drive(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      chk($sformatf("loop%0d dec1", k), 32'(contrl1), 32'd0);
      chk($sformatf("loop%0d hold1", k), 32'(grant), 32'(eg));
      tick();
      chk($sformatf("loop%0d done", k), 32'(contrl1), 32'd1);
      chk($sformatf("loop%0d hold2", k), 32'(grant), 32'(eg));
      if (contrl1) pulses++;
      drive(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("loop pulse count", 32'(pulses), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
